// File: rtl/bit_serializer_16_pkg.sv
// bit_serializer_16_pkg: shared widths and FSM state type for the bit serializer
package bit_serializer_16_pkg;
  localparam int SER_WIDTH     = 16;
  localparam int SER_SEL_WIDTH = 4;
  typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;
endpackage

// File: rtl/bit_serializer_16_if.sv
// bit_serializer_16_if: word-in / bit-out valid-ready bundle plus observability (sel, busy)
interface bit_serializer_16_if;
  import bit_serializer_16_pkg::*;
  logic                     in_valid;
  logic                     in_ready;
  logic [SER_WIDTH-1:0]     in_data;
  logic                     out_bit;
  logic                     out_valid;
  logic                     out_ready;
  logic                     out_last;
  logic [SER_SEL_WIDTH-1:0] sel;
  logic                     busy;
  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_bit, out_valid, out_last, sel, busy);
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_bit, out_valid, out_last, sel, busy);
endinterface

// File: rtl/bit_serializer_16_mux.sv
// bit_serializer_16_mux: 16:1 single-bit mux; i_d word, i_s select, o_y = i_d[i_s]
module bit_serializer_16_mux
  import bit_serializer_16_pkg::*;
(
  input  logic [SER_WIDTH-1:0]     i_d,
  input  logic [SER_SEL_WIDTH-1:0] i_s,
  output logic                     o_y
);
  assign o_y = i_d[i_s];
endmodule

// File: rtl/bit_serializer_16.sv
// bit_serializer_16: captures a 16-bit word and emits it one bit per accepted beat
//   i_clk  rising-edge clock      i_rst  async active-high reset
//   bus    slave side: in_valid/in_ready/in_data word stream, out_bit/out_valid/
//          out_ready/out_last bit stream, sel (mux select), busy (word in flight)
module bit_serializer_16
  import bit_serializer_16_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
)(
  input  logic                 i_clk,
  input  logic                 i_rst,
  bit_serializer_16_if.slave   bus
);
  state_t                   r_state;
  logic [SER_SEL_WIDTH-1:0] r_cnt;
  logic [SER_WIDTH-1:0]     r_shadow;
  logic w_shift, w_last, w_in_ready, w_accept, w_advance;
  assign w_shift    = r_state == ST_SHIFT;
  assign w_last     = w_shift && r_cnt == 4'hF;
  // a new word may slip in on the final beat so consecutive words have no bubble
  assign w_in_ready = !i_rst && (!w_shift || (w_last && bus.out_ready));
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_advance  = w_shift && bus.out_ready;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_shadow <= '0;
    end else if (w_accept) begin
      r_state  <= ST_SHIFT;
      r_cnt    <= '0;
      r_shadow <= bus.in_data;
    end else if (w_advance) begin
      r_cnt    <= r_cnt + 4'd1;
      r_state  <= w_last ? ST_IDLE : ST_SHIFT;
    end
  // select parks at 0 when idle so reset shows sel=0 for either bit order
  assign bus.sel       = w_shift ? (MSB_FIRST ? ~r_cnt : r_cnt) : '0;
  assign bus.out_valid = w_shift;
  assign bus.busy      = w_shift;
  assign bus.out_last  = w_last;
  assign bus.in_ready  = w_in_ready;
  bit_serializer_16_mux u_mux (
    .i_d (r_shadow),
    .i_s (bus.sel),
    .o_y (bus.out_bit)
  );
endmodule

// File: tb/tb_bit_serializer_16.sv
// tb_bit_serializer_16: LSB-first and MSB-first serializers driven in lockstep against a word/bit-index model
module tb_bit_serializer_16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bit_serializer_16_if b0 ();
  bit_serializer_16_if b1 ();
  bit_serializer_16 #(.MSB_FIRST(1'b0)) u0 (.i_clk(clk), .i_rst(rst), .bus(b0));
  bit_serializer_16 #(.MSB_FIRST(1'b1)) u1 (.i_clk(clk), .i_rst(rst), .bus(b1));

  int n_chk = 0;
  int n_pass = 0;
  logic        cur_v, cur_r;
  logic [15:0] cur_d;
  logic [15:0] m_word;
  int          m_k;
  bit          m_act;
  logic [15:0] col0, col1;
  int beats, ones, idle_cnt;

  typedef struct {
    logic v; logic [15:0] d; logic r;
    logic e_rdy; logic e_val; logic e_last; logic e_bit; logic [3:0] e_sel;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %h expected %h", n, a, e);
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic r);
    cur_v = v; cur_d = d; cur_r = r;
    b0.in_valid = v; b0.in_data = d; b0.out_ready = r;
    b1.in_valid = v; b1.in_data = d; b1.out_ready = r;
  endtask

  task automatic model_reset();
    m_word = '0; m_k = 0; m_act = 1'b0;
  endtask

  task automatic check_model();
    logic er, el;
    er = !m_act || (m_k == 15 && cur_r);
    el = m_act && m_k == 15;
    chk("in_ready0",  16'(b0.in_ready),  16'(er));
    chk("in_ready1",  16'(b1.in_ready),  16'(er));
    chk("out_valid0", 16'(b0.out_valid), 16'(m_act));
    chk("out_valid1", 16'(b1.out_valid), 16'(m_act));
    chk("busy0",      16'(b0.busy),      16'(m_act));
    chk("busy1",      16'(b1.busy),      16'(m_act));
    chk("out_last0",  16'(b0.out_last),  16'(el));
    chk("out_last1",  16'(b1.out_last),  16'(el));
    chk("sel0", 16'(b0.sel), m_act ? 16'(m_k) : 16'h0);
    chk("sel1", 16'(b1.sel), m_act ? 16'(15 - m_k) : 16'h0);
    if (m_act) begin
      chk("out_bit0", 16'(b0.out_bit), 16'(m_word[m_k]));
      chk("out_bit1", 16'(b1.out_bit), 16'(m_word[15 - m_k]));
    end
  endtask

  task automatic tick();
    if (b0.out_valid && cur_r) begin
      col0 = {b0.out_bit, col0[15:1]};
      col1 = {col1[14:0], b1.out_bit};
      beats++;
      if (b0.out_bit) ones++;
    end
    if (!b0.busy) idle_cnt++;
    @(posedge clk);
    if (cur_v && (!m_act || (m_k == 15 && cur_r))) begin
      m_word = cur_d; m_k = 0; m_act = 1'b1;
    end else if (m_act && cur_r) begin
      m_k++;
      if (m_k == 16) begin m_k = 0; m_act = 1'b0; end
    end
    @(negedge clk);
  endtask

  task automatic cycle(input logic v, input logic [15:0] d, input logic r);
    drive(v, d, r);
    #1;
    check_model();
    tick();
  endtask

  task automatic clear_obs();
    col0 = '0; col1 = '0; beats = 0; ones = 0; idle_cnt = 0;
  endtask

  task automatic send_word(input logic [15:0] w, input bit toggle);
    int cyc;
    clear_obs();
    cycle(1'b1, w, 1'b1);
    cyc = 0;
    while (beats < 16 && cyc < 100) begin
      cycle(1'b0, 16'h0, toggle ? logic'(cyc % 2 == 0) : 1'b1);
      cyc++;
    end
    chk("word_lsb_order", col0, w);
    chk("word_msb_order", col1, w);
    chk("word_beats", 16'(beats), 16'd16);
    chk("word_cycles", 16'(cyc), toggle ? 16'd31 : 16'd16);
    drive(1'b0, 16'h0, 1'b1);
    #1;
    chk("idle_after_word", 16'(b0.busy), 16'h0);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
    tbl[1] = '{1'b1, 16'h5555, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
    tbl[2] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0};
    tbl[3] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1};
    tbl[4] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1};
    tbl[5] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1};
    tbl[6] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd2};
    drive(1'b0, 16'h0, 1'b1);
    model_reset();
    clear_obs();
    repeat (3) @(negedge clk);
    chk("rst_in_ready",  16'(b0.in_ready),  16'h0);
    chk("rst_out_valid", 16'(b0.out_valid), 16'h0);
    chk("rst_sel1",      16'(b1.sel),       16'h0);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].r);
      #1;
      chk($sformatf("tbl%0d_in_ready", i),  16'(b0.in_ready),  16'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d_out_valid", i), 16'(b0.out_valid), 16'(tbl[i].e_val));
      chk($sformatf("tbl%0d_out_last", i),  16'(b0.out_last),  16'(tbl[i].e_last));
      chk($sformatf("tbl%0d_out_bit", i),   16'(b0.out_bit),   16'(tbl[i].e_bit));
      chk($sformatf("tbl%0d_sel", i),       16'(b0.sel),       16'(tbl[i].e_sel));
      check_model();
      tick();
    end
    for (int i = 0; i < 40 && m_act; i++) cycle(1'b0, 16'h0, 1'b1);
    chk("drain_done", 16'(b0.busy), 16'h0);

    send_word(16'h5555, 1'b0);
    send_word(16'h8001, 1'b0);
    send_word(16'hA5C3, 1'b1);

    clear_obs();
    cycle(1'b1, 16'h1234, 1'b1);
    repeat (7) cycle(1'b0, 16'h0, 1'b1);
    drive(1'b0, 16'h0, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid0", 16'(b0.out_valid), 16'h0);
    chk("midrst_busy0",      16'(b0.busy),      16'h0);
    chk("midrst_sel0",       16'(b0.sel),       16'h0);
    chk("midrst_sel1",       16'(b1.sel),       16'h0);
    chk("midrst_in_ready0",  16'(b0.in_ready),  16'h0);
    chk("midrst_out_last1",  16'(b1.out_last),  16'h0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    beats = 0;
    repeat (20) cycle(1'b0, 16'h0, 1'b1);
    chk("no_stale_beats", 16'(beats), 16'h0);

    clear_obs();
    cycle(1'b1, 16'hFFFF, 1'b1);
    idle_cnt = 0;
    repeat (16) cycle(1'b1, 16'h0000, 1'b1);
    repeat (16) cycle(1'b0, 16'h0, 1'b1);
    chk("b2b_beats", 16'(beats), 16'd32);
    chk("b2b_ones", 16'(ones), 16'd16);
    chk("b2b_busy_never_dropped", 16'(idle_cnt), 16'h0);
    chk("b2b_second_word", col0, 16'h0000);

    clear_obs();
    cycle(1'b1, 16'h00FF, 1'b1);
    repeat (3) cycle(1'b0, 16'h0, 1'b1);
    drive(1'b1, 16'hDEAD, 1'b1);
    #1;
    chk("ignore_midword_in_ready", 16'(b0.in_ready), 16'h0);
    check_model();
    tick();
    repeat (12) cycle(1'b1, 16'hDEAD, 1'b1);
    chk("ignore_first_word", col0, 16'h00FF);
    clear_obs();
    repeat (17) cycle(1'b0, 16'h0, 1'b1);
    chk("ignore_deferred_word", col0, 16'hDEAD);
    chk("ignore_deferred_msb", col1, 16'hDEAD);

    for (int i = 0; i < 400; i++)
      cycle(logic'($urandom_range(0, 2) == 0), 16'($urandom), logic'($urandom_range(0, 3) != 0));
    repeat (20) cycle(1'b0, 16'h0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
